// File: rtl/ontransit_initiator.sv
// ontransit_initiator
//   Initiator end of the do/g/s on-transit handshake. A burst command
//   (unit count) is taken from the control interface. The initiator then
//   raises 'do' towards the responder and counts grant pulses 'g' until the
//   burst is complete. After that it drops 'do' and waits for the stop
//   acknowledge 's' before it returns to IDLE.
//
// Optional feature macro: ONTRANSIT_TIMEOUT_EN
//   When defined, a watchdog aborts a burst with an err pulse. It fires after
//   TO_CYCLES consecutive cycles in RUN without g, or in WAIT_S without s.
//   When undefined, there is no watchdog and the initiator waits forever.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   cmd_valid  in   command offered
//   cmd_len    in   grants to collect (0 = null command, completes at once)
//   cmd_ready  out  high while IDLE (combinational from state)
//   o_do       out  request to responder, registered ('do' is a reserved word)
//   g          in   grant pulse, one unit per high cycle
//   s          in   stop acknowledge
//   busy       out  state != IDLE, registered
//   done       out  one-cycle pulse: burst completed and acknowledged
//   err        out  one-cycle pulse: early stop or watchdog abort
//   dbg_state  out  current FSM state encoding (0 IDLE, 1 RUN, 2 WAIT_S)
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_len must be stable while cmd_valid is high.
module ontransit_initiator #(
  parameter int LEN_W     = 8,
  parameter int TO_W      = 8,
  parameter int TO_CYCLES = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_ready,
  output logic             o_do,
  input  logic             g,
  input  logic             s,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_WAIT_S = 2'd2
  } state_t;

  state_t           r_state;
  logic [LEN_W-1:0] r_remaining;
  logic             r_do;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  state_t           w_next_state;
  logic [LEN_W-1:0] w_next_remaining;
  logic             w_next_do;
  logic             w_next_done;
  logic             w_next_err;
  logic             w_last;
  logic             w_timeout;

  // Current grant is the final unit of the burst.
  assign w_last = (r_remaining == LEN_W'(1));

`ifdef ONTRANSIT_TIMEOUT_EN
  logic [TO_W-1:0] r_wd;
  logic            w_wd_clr;

  // The counter holds the number of idle cycles already seen. The abort
  // therefore happens on the cycle that would make it reach TO_CYCLES.
  assign w_timeout = (r_wd == TO_W'(TO_CYCLES - 1));

  // Activity is g in RUN or s anywhere. Any state change also restarts
  // the count, so each RUN/WAIT_S entry begins from zero.
  assign w_wd_clr = (r_state == ST_IDLE) || (w_next_state != r_state) ||
                    ((r_state == ST_RUN) && g) || s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wd <= '0;
    end else if (w_wd_clr) begin
      r_wd <= '0;
    end else begin
      r_wd <= r_wd + TO_W'(1);
    end
  end
`else
  // No watchdog in this build; the parameters are only folded here.
  logic w_unused_cfg;
  assign w_unused_cfg = ^{TO_W[0], TO_CYCLES[0]};
  assign w_timeout    = 1'b0;
`endif

  always_comb begin
    w_next_state     = r_state;
    w_next_remaining = r_remaining;
    w_next_do        = 1'b0;
    w_next_done      = 1'b0;
    w_next_err       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // g and s are ignored here.
        if (cmd_valid) begin
          if (cmd_len != '0) begin
            w_next_remaining = cmd_len;
            w_next_do        = 1'b1;
            w_next_state     = ST_RUN;
          end else begin
            w_next_done = 1'b1;
          end
        end
      end
      ST_RUN: begin
        w_next_do = 1'b1;
        // Guarded decrement: the counter can never wrap below zero.
        if (g && (r_remaining != '0)) begin
          w_next_remaining = r_remaining - LEN_W'(1);
        end
        if (s) begin
          // Stop with the final grant is a clean finish that skips WAIT_S.
          // Any other stop in RUN is an early stop.
          w_next_do    = 1'b0;
          w_next_state = ST_IDLE;
          if (g && w_last) begin
            w_next_done = 1'b1;
          end else begin
            w_next_err = 1'b1;
          end
        end else if (g) begin
          if (w_last) begin
            w_next_do    = 1'b0;
            w_next_state = ST_WAIT_S;
          end
        end else if (w_timeout) begin
          w_next_do    = 1'b0;
          w_next_err   = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      ST_WAIT_S: begin
        if (s) begin
          w_next_done  = 1'b1;
          w_next_state = ST_IDLE;
        end else if (w_timeout) begin
          w_next_err   = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_do        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_remaining <= w_next_remaining;
      r_do        <= w_next_do;
      r_busy      <= (w_next_state != ST_IDLE);
      r_done      <= w_next_done;
      r_err       <= w_next_err;
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign o_do      = r_do;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule
